// File: rtl/tone_arbiter.sv
// tone_arbiter: three-requester tone arbiter with fixed-priority alarm, round-robin
// key/sequence requesters, preemption of non-alarm tones, and a square-wave speaker driver.
module tone_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [8:0]  code,
    input  logic [17:0] dur,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic [2:0]  abort,
    output logic        busy,
    output logic [2:0]  sound,
    output logic        speaker
);
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
    state_t state;
    logic rr;
    logic [1:0] pick;
    logic [2:0] pcode, thr, tc;
    logic [5:0] pdur, cnt;
    logic silent;
    // rr set means requester 2 is favoured when 1 and 2 both request
    always_comb begin
        pick = req[0] ? 2'd0 : (req[1] && !(req[2] && rr)) ? 2'd1 : 2'd2;
        pcode = pick == 2'd0 ? code[2:0] : pick == 2'd1 ? code[5:3] : code[8:6];
        pdur = pick == 2'd0 ? dur[5:0] : pick == 2'd1 ? dur[11:6] : dur[17:12];
        thr = (sound == 3'd5) ? 3'd1 : sound + 3'd2;
        silent = sound[2] & sound[1];
    end
    assign busy = state != IDLE;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            rr <= 1'b0;
            cnt <= '0;
            tc <= '0;
            gnt <= '0;
            done <= '0;
            abort <= '0;
            sound <= '0;
            speaker <= 1'b0;
        end else begin
            done <= '0;
            abort <= '0;
            case (state)
                IDLE: if (|req) begin
                    state <= PLAY;
                    gnt <= 3'b001 << pick;
                    sound <= pcode;
                    cnt <= pdur;
                    tc <= '0;
                    speaker <= 1'b0;
                    if (pick != 2'd0) rr <= pick == 2'd1;
                end
                PLAY: if (req[0] && !gnt[0]) begin
                    abort <= gnt;
                    gnt <= 3'b001;
                    sound <= code[2:0];
                    cnt <= dur[5:0];
                    tc <= '0;
                    speaker <= 1'b0;
                end else if (cnt == '0) begin
                    state <= GAP;
                    done <= gnt;
                    gnt <= '0;
                    sound <= '0;
                    cnt <= 6'd1;
                    tc <= '0;
                    speaker <= 1'b0;
                end else begin
                    cnt <= cnt - 6'd1;
                    tc <= (silent || tc > thr) ? 3'd0 : tc + 3'd1;
                    speaker <= silent ? 1'b0 : (tc > thr) ? ~speaker : speaker;
                end
                GAP: if (cnt == '0) state <= IDLE; else cnt <= cnt - 6'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
